rtc_access_arbiter: RTL and testbench

RTC_ACCESS_ARBITER -- requirements
Module: rtc_access_arbiter

---
 rtl/rtc_pkg.sv | 15 +
 rtl/rtc_alarm_cmp.sv | 58 +++++
 rtl/rtc_access_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_rtc_access_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_pkg.sv
// rtc_pkg
// Shared definitions for the RTC access arbiter slice.
//   arb_state_e         : arbiter FSM state encoding (BOOT / IDLE / BUSY)
//   BOOT_CYCLES_DEFAULT : default length of the post-reset boot hold, in clk cycles
package rtc_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_BUSY = 2'd2
    } arb_state_e;

    localparam int BOOT_CYCLES_DEFAULT = 1034;

endpackage

// File: rtl/rtc_alarm_cmp.sv
// rtc_alarm_cmp
// Compares the current RTC counter fields against the alarm target fields and
// latches a ring flag on a match until software acknowledges it.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset (clears ring)
//   enable_i       : compare enable; low while the arbiter is in its boot hold
//   alm_cur_i      : ALM_FIELDS packed current counter fields, DATA_W bits each
//   alm_tgt_i      : ALM_FIELDS packed target fields, same packing
//   alm_ack_i      : clears ring unless a match is present in the same cycle
//   ring_o         : latched alarm / timer-expiry flag
module rtc_alarm_cmp #(
    parameter int ALM_FIELDS = 3,
    parameter int DATA_W     = 8
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         enable_i,
    input  logic [ALM_FIELDS*DATA_W-1:0] alm_cur_i,
    input  logic [ALM_FIELDS*DATA_W-1:0] alm_tgt_i,
    input  logic                         alm_ack_i,
    output logic                         ring_o
);

    logic fieldsEq;
    logic tgtZero;
    logic match;
    logic ring_q;

    // A match needs every field equal and a target that is not all zero, so an
    // unprogrammed (cleared) alarm never fires. Compare is suppressed during boot.
    always_comb begin
        fieldsEq = 1'b1;
        tgtZero  = 1'b1;
        for (int f = 0; f < ALM_FIELDS; f++) begin
            if (alm_cur_i[f*DATA_W +: DATA_W] != alm_tgt_i[f*DATA_W +: DATA_W]) begin
                fieldsEq = 1'b0;
            end
            if (alm_tgt_i[f*DATA_W +: DATA_W] != '0) begin
                tgtZero = 1'b0;
            end
        end
        match = enable_i && fieldsEq && !tgtZero;
    end

    // Set has priority over acknowledge so a held match cannot be cleared away.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ring_q <= 1'b0;
        end else if (match) begin
            ring_q <= 1'b1;
        end else if (alm_ack_i) begin
            ring_q <= 1'b0;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/rtc_access_arbiter.sv
// rtc_access_arbiter
// Arbitrates NUM_CH requesters onto a single RTC register bus. After reset the
// bus is held by channel 0 for BOOT_CYCLES cycles; afterwards one requester at a
// time owns a frame, whose address/data/direction are frozen until frame_done_i.
// Optional build macro: RTC_ARB_RR_EN selects round-robin arbitration
// (default build: fixed priority, lowest index wins).
// Ports:
//   clk_i, reset_i           : clock, synchronous active-high reset
//   req_i, req_wr_i          : per-channel request level and direction (1 = write)
//   req_addr_i, req_wdata_i  : per-channel address/data, channel i at [i*DATA_W +: DATA_W]
//   frame_done_i             : end-of-frame pulse from the bus protocol engine
//   grant_o                  : one-hot owner, zero when idle
//   bus_addr_o, bus_wdata_o  : owner's address/data, zero when idle
//   bus_wr_o, bus_active_o   : owner's direction, frame-owned flag
//   booting_o                : high during the boot hold
//   alm_cur_i, alm_tgt_i     : alarm current/target fields
//   alm_ack_i, ring_o        : alarm acknowledge, latched alarm flag
module rtc_access_arbiter
    import rtc_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int DATA_W      = 8,
    parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT,
    parameter int ALM_FIELDS  = 3
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_CH-1:0]            req_i,
    input  logic [NUM_CH-1:0]            req_wr_i,
    input  logic [NUM_CH*DATA_W-1:0]     req_addr_i,
    input  logic [NUM_CH*DATA_W-1:0]     req_wdata_i,
    input  logic                         frame_done_i,
    output logic [NUM_CH-1:0]            grant_o,
    output logic [DATA_W-1:0]            bus_addr_o,
    output logic [DATA_W-1:0]            bus_wdata_o,
    output logic                         bus_wr_o,
    output logic                         bus_active_o,
    output logic                         booting_o,
    input  logic [ALM_FIELDS*DATA_W-1:0] alm_cur_i,
    input  logic [ALM_FIELDS*DATA_W-1:0] alm_tgt_i,
    input  logic                         alm_ack_i,
    output logic                         ring_o
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(BOOT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bootCnt_q, bootCnt_d;
    logic [IDX_W-1:0]  owner_q;
    logic [DATA_W-1:0] addr_q, wdata_q;
    logic              wr_q;
    logic [IDX_W-1:0]  selIdx;
    logic [IDX_W-1:0]  cand;
    logic              selAny;

`ifdef RTC_ARB_RR_EN
    logic [IDX_W-1:0]  rrPtr_q, rrPtr_d;

    // Round-robin pick: scan from the farthest candidate back to the nearest so
    // the channel closest after the last completed owner is the one kept.
    always_comb begin
        selAny = 1'b0;
        selIdx = '0;
        cand   = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            cand = IDX_W'((int'(rrPtr_q) + k) % NUM_CH);
            if (req_i[cand]) begin
                selAny = 1'b1;
                selIdx = cand;
            end
        end
    end

    // The pointer only advances when a frame really completes, and starts at the
    // last channel so channel 0 is searched first after reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rrPtr_q <= IDX_W'(NUM_CH - 1);
        end else begin
            rrPtr_q <= rrPtr_d;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (state_q == ST_BUSY && frame_done_i) begin
            rrPtr_d = owner_q;
        end
    end
`else
    // Fixed-priority pick: scanning downwards leaves the lowest requesting index.
    always_comb begin
        selAny = 1'b0;
        selIdx = '0;
        cand   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            cand = IDX_W'(i);
            if (req_i[cand]) begin
                selAny = 1'b1;
                selIdx = cand;
            end
        end
    end
`endif

    // State and boot counter register; reset aborts any frame and restarts boot.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_BOOT;
            bootCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bootCnt_q <= bootCnt_d;
        end
    end

    // Frame snapshot taken at grant time so later requester activity is ignored.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            owner_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (state_q == ST_IDLE && selAny) begin
            owner_q <= selIdx;
            addr_q  <= req_addr_i[selIdx*DATA_W +: DATA_W];
            wdata_q <= req_wdata_i[selIdx*DATA_W +: DATA_W];
            wr_q    <= req_wr_i[selIdx];
        end
    end

    // Next-state logic. Leaving BUSY always goes through IDLE, which gives the
    // mandatory idle cycle between frames; frame_done outside BUSY is ignored.
    always_comb begin
        state_d   = state_q;
        bootCnt_d = bootCnt_q;
        case (state_q)
            ST_BOOT: begin
                if (bootCnt_q == BOOT_LAST) begin
                    state_d   = ST_IDLE;
                    bootCnt_d = '0;
                end else begin
                    bootCnt_d = bootCnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (selAny) begin
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (frame_done_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // Output decode. During boot channel 0 owns the bus with its live request
    // fields; in BUSY the frozen snapshot drives the bus; otherwise all zero.
    always_comb begin
        grant_o      = '0;
        bus_addr_o   = '0;
        bus_wdata_o  = '0;
        bus_wr_o     = 1'b0;
        bus_active_o = 1'b0;
        booting_o    = 1'b0;
        case (state_q)
            ST_BOOT: begin
                grant_o      = NUM_CH'(1);
                bus_addr_o   = req_addr_i[DATA_W-1:0];
                bus_wdata_o  = req_wdata_i[DATA_W-1:0];
                bus_wr_o     = req_wr_i[0];
                bus_active_o = 1'b1;
                booting_o    = 1'b1;
            end
            ST_BUSY: begin
                grant_o      = NUM_CH'(1) << owner_q;
                bus_addr_o   = addr_q;
                bus_wdata_o  = wdata_q;
                bus_wr_o     = wr_q;
                bus_active_o = 1'b1;
            end
            default: begin
                grant_o = '0;
            end
        endcase
    end

    rtc_alarm_cmp #(
        .ALM_FIELDS (ALM_FIELDS),
        .DATA_W     (DATA_W)
    ) u_alarm (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .enable_i   (state_q != ST_BOOT),
        .alm_cur_i  (alm_cur_i),
        .alm_tgt_i  (alm_tgt_i),
        .alm_ack_i  (alm_ack_i),
        .ring_o     (ring_o)
    );

endmodule

// File: tb/tb_rtc_access_arbiter.sv
// tb_rtc_access_arbiter
// Scoreboard bench for rtc_access_arbiter. A reference model advances on each
// rising edge from the applied inputs and queues the expected bus view; a
// monitor on the falling edge pops and compares it with the DUT outputs.
// Honors RTC_ARB_RR_EN the same way as the design.
module tb_rtc_access_arbiter;

    localparam int NUM_CH      = 4;
    localparam int DATA_W      = 8;
    localparam int BOOT_CYCLES = 1034;
    localparam int ALM_FIELDS  = 3;

    logic                         clk = 1'b0;
    logic                         reset;
    logic [NUM_CH-1:0]            req;
    logic [NUM_CH-1:0]            reqWr;
    logic [NUM_CH*DATA_W-1:0]     reqAddr;
    logic [NUM_CH*DATA_W-1:0]     reqWdata;
    logic                         frameDone;
    logic [NUM_CH-1:0]            grant;
    logic [DATA_W-1:0]            busAddr;
    logic [DATA_W-1:0]            busWdata;
    logic                         busWr;
    logic                         busActive;
    logic                         booting;
    logic [ALM_FIELDS*DATA_W-1:0] almCur;
    logic [ALM_FIELDS*DATA_W-1:0] almTgt;
    logic                         almAck;
    logic                         ring;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit               boot;
        bit               busy;
        int               owner;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit               wr;
        bit               ring;
    } exp_t;

    exp_t expQ[$];

    always #5 clk = ~clk;

    rtc_access_arbiter #(
        .NUM_CH      (NUM_CH),
        .DATA_W      (DATA_W),
        .BOOT_CYCLES (BOOT_CYCLES),
        .ALM_FIELDS  (ALM_FIELDS)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset),
        .req_i        (req),
        .req_wr_i     (reqWr),
        .req_addr_i   (reqAddr),
        .req_wdata_i  (reqWdata),
        .frame_done_i (frameDone),
        .grant_o      (grant),
        .bus_addr_o   (busAddr),
        .bus_wdata_o  (busWdata),
        .bus_wr_o     (busWr),
        .bus_active_o (busActive),
        .booting_o    (booting),
        .alm_cur_i    (almCur),
        .alm_tgt_i    (almTgt),
        .alm_ack_i    (almAck),
        .ring_o       (ring)
    );

    // Reference model state, kept as plain counters and flags.
    bit               mBoot  = 1'b0;
    bit               mBusy  = 1'b0;
    int               bootCount = 0;
    int               ownerM = 0;
    logic [DATA_W-1:0] capAddr  = '0;
    logic [DATA_W-1:0] capWdata = '0;
    bit               capWr  = 1'b0;
    bit               ringM  = 1'b0;
`ifdef RTC_ARB_RR_EN
    int               lastOwner = NUM_CH - 1;
`endif

    // Winner for a request vector: round-robin starts after the last finished
    // owner, fixed priority simply starts at channel 0.
    function automatic int pickOwner(input logic [NUM_CH-1:0] r);
        int start;
        int idx;
        int rInt;
        rInt = int'(r);
`ifdef RTC_ARB_RR_EN
        start = lastOwner + 1;
`else
        start = 0;
`endif
        for (int d = 0; d < NUM_CH; d++) begin
            idx = (start + d) % NUM_CH;
            if ((rInt & (1 << idx)) != 0) return idx;
        end
        return -1;
    endfunction

    // Model step on each rising edge, then queue what the bus should look like.
    always @(posedge clk) begin
        exp_t e;
        int   w;
        if (reset) begin
            mBoot     = 1'b1;
            mBusy     = 1'b0;
            bootCount = 0;
            ringM     = 1'b0;
`ifdef RTC_ARB_RR_EN
            lastOwner = NUM_CH - 1;
`endif
        end else begin
            if (!mBoot && almCur == almTgt && almTgt != '0) ringM = 1'b1;
            else if (almAck) ringM = 1'b0;
            if (mBoot) begin
                if (bootCount == BOOT_CYCLES - 1) mBoot = 1'b0;
                else bootCount++;
            end else if (mBusy) begin
                if (frameDone) begin
                    mBusy = 1'b0;
`ifdef RTC_ARB_RR_EN
                    lastOwner = ownerM;
`endif
                end
            end else begin
                w = pickOwner(req);
                if (w >= 0) begin
                    mBusy    = 1'b1;
                    ownerM   = w;
                    capAddr  = reqAddr[w*DATA_W +: DATA_W];
                    capWdata = reqWdata[w*DATA_W +: DATA_W];
                    capWr    = reqWr[w];
                end
            end
        end
        e.boot  = mBoot;
        e.busy  = mBusy;
        e.owner = ownerM;
        e.addr  = capAddr;
        e.wdata = capWdata;
        e.wr    = capWr;
        e.ring  = ringM;
        expQ.push_back(e);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor: away from the active edge, pop one expectation and compare.
    always @(negedge clk) begin
        exp_t e;
        logic [NUM_CH-1:0] eGrant;
        logic [DATA_W-1:0] eAddr, eWdata;
        logic eWr, eActive;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            eGrant = '0; eAddr = '0; eWdata = '0; eWr = 1'b0; eActive = 1'b0;
            if (e.boot) begin
                eGrant  = NUM_CH'(1);
                eAddr   = reqAddr[DATA_W-1:0];
                eWdata  = reqWdata[DATA_W-1:0];
                eWr     = reqWr[0];
                eActive = 1'b1;
            end else if (e.busy) begin
                eGrant  = NUM_CH'(1) << e.owner;
                eAddr   = e.addr;
                eWdata  = e.wdata;
                eWr     = e.wr;
                eActive = 1'b1;
            end
            checkOutput("grant",      32'(grant),     32'(eGrant));
            checkOutput("bus_addr",   32'(busAddr),   32'(eAddr));
            checkOutput("bus_wdata",  32'(busWdata),  32'(eWdata));
            checkOutput("bus_wr",     32'(busWr),     32'(eWr));
            checkOutput("bus_active", 32'(busActive), 32'(eActive));
            checkOutput("booting",    32'(booting),   32'(e.boot));
            checkOutput("ring",       32'(ring),      32'(e.ring));
        end
    end

    // Drive one cycle of control inputs, held across the next rising edge.
    task automatic applyStimulus(input logic rstV, input logic [NUM_CH-1:0] reqV,
                                 input logic doneV, input logic ackV);
        reset     = rstV;
        req       = reqV;
        frameDone = doneV;
        almAck    = ackV;
        @(posedge clk);
        #1;
    endtask

    task automatic runFrame(input logic [NUM_CH-1:0] reqV, input int busyCycles);
        for (int i = 0; i < busyCycles; i++) applyStimulus(1'b0, reqV, 1'b0, 1'b0);
        applyStimulus(1'b0, reqV, 1'b1, 1'b0);
    endtask

    initial begin
        reset = 1'b1; req = '0; reqWr = '0; frameDone = 1'b0; almAck = 1'b0;
        reqAddr = '0; reqWdata = '0; almCur = '0; almTgt = '0;
        #1;
        $display("[TB] reset and boot hold");
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        applyStimulus(1'b1, '0, 1'b0, 1'b0);
        reqAddr = 32'h44332211; reqWdata = 32'hD4C3B2A1; reqWr = 4'b0101;
        for (int i = 0; i < BOOT_CYCLES + 4; i++) applyStimulus(1'b0, '0, i[4], 1'b0);

        $display("[TB] simultaneous requests 0110");
        applyStimulus(1'b0, 4'b0110, 1'b0, 1'b0);
        runFrame(4'b0110, 2);
        runFrame(4'b0100, 3);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] owner changes address and drops request mid-frame");
        reqAddr[15:8] = 8'h41;
        applyStimulus(1'b0, 4'b0010, 1'b0, 1'b0);
        reqAddr[15:8] = 8'h55;
        runFrame(4'b0000, 4);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] all channels requesting");
        for (int f = 0; f < 5; f++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
            runFrame(4'b1111, 2);
        end
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);

        $display("[TB] alarm set, ack while matching, zero target");
        almTgt = {8'h00, 8'h05, 8'h30}; almCur = almTgt;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        almCur = 24'h000531;
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        almTgt = '0; almCur = '0;
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0);

        $display("[TB] reset while channel 3 owns the bus");
        almTgt = 24'h000102; almCur = almTgt;
        applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);
        applyStimulus(1'b1, 4'b1000, 1'b0, 1'b0);
        for (int i = 0; i < BOOT_CYCLES + 2; i++) applyStimulus(1'b0, 4'b1000, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 3000; i++) begin
            reqAddr  = $urandom;
            reqWdata = $urandom;
            reqWr    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) almTgt = ($urandom_range(0, 3) == 0) ? '0 : 24'($urandom);
            almCur = ($urandom_range(0, 3) == 0) ? almTgt : 24'($urandom);
            applyStimulus(($urandom_range(0, 1499) == 0), 4'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
